// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared types and constants for the reset sequencer.
//                Defines the sequencer state encoding and the reset-cause
//                codes reported on reset_cause.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        COUNT     = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } seq_state_e;

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/reset_sync.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sync
//  Description : Asynchronous-assert / synchronous-deassert reset
//                synchroniser. The output drops as soon as rst_n drops and
//                rises SYNC_STAGES clk edges after rst_n rises.
//  Ports       : clk        - destination clock
//                rst_n      - asynchronous active-low reset in
//                rst_sync_n - synchronised active-low reset out
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_sync_n
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // A constant 1 walks through the chain once reset is lifted.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/reset_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_gen
//  Description : Reset sequencer. Waits for the board reset to be lifted and
//                for PLL lock, holds all domains for RESET_CYCLES, then
//                releases the domain resets one by one, STAGGER_CYCLES apart.
//                Loss of lock or a software request re-runs the sequence.
//  Ports       : clk         - system clock
//                rst_n       - board reset, asynchronous, active-low
//                pll_lock    - PLL lock, asynchronous to clk
//                sw_rst_req  - single-cycle software reset request
//                dom_rst_n   - per-domain active-low resets, bit 0 first
//                ready       - all domains released
//                reset_cause - 0 board/POR, 1 lock loss, 2 software
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_gen
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS    = 4,
    parameter int RESET_CYCLES   = 100,
    parameter int STAGGER_CYCLES = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int CTR_WIDTH      = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_lock,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   ready,
    output logic [1:0]             reset_cause
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CTR_WIDTH-1:0] RESET_LAST   = CTR_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] STAGGER_LAST = CTR_WIDTH'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

    logic                   rst_sync_n;
    logic                   lock_s;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_d;

    seq_state_e             state_q,  state_d;
    logic [CTR_WIDTH-1:0]   ctr_q,    ctr_d;
    logic [IDX_W-1:0]       idx_q,    idx_d;
    logic [NUM_DOMAINS-1:0] dom_q,    dom_d;
    logic                   ready_q,  ready_d;
    logic [1:0]             cause_q,  cause_d;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .rst_sync_n (rst_sync_n)
    );

    // Lock synchroniser: plain flop chain, cleared by the board reset.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_lock};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= lock_sync_d;
        end
    end

    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        ready_d = ready_q;
        cause_d = cause_q;

        case (state_q)
            IDLE: begin
                if (rst_sync_n) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = COUNT;
                    ctr_d   = '0;
                end
            end
            COUNT: begin
                if (ctr_q == RESET_LAST) begin
                    dom_d[0] = 1'b1;
                    ctr_d    = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = RELEASE;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_WIDTH'(1);
                end
            end
            RELEASE: begin
                if (ctr_q == STAGGER_LAST) begin
                    ctr_d = '0;
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            dom_d[k] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    ctr_d = ctr_q + CTR_WIDTH'(1);
                end
            end
            RUN: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides any progress made this cycle. Lock loss wins the
        // cause code when it coincides with a software request.
        if (((state_q == COUNT) || (state_q == RELEASE) || (state_q == RUN)) &&
            (!lock_s || sw_rst_req)) begin
            state_d = WAIT_LOCK;
            ctr_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            ready_d = 1'b0;
            cause_d = !lock_s ? CAUSE_LOCK : CAUSE_SW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            ready_q <= 1'b0;
            cause_q <= CAUSE_POR;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    assign dom_rst_n   = dom_q;
    assign ready       = ready_q;
    assign reset_cause = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_seq_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reset_seq_gen
//  Description : Self-checking bench for reset_seq_gen. A mode/time-stamp
//                reference model predicts every output each cycle; directed
//                steps add absolute edge-number schedule checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_seq_gen;

    localparam int ND = 3;
    localparam int RC = 5;
    localparam int SC = 3;
    localparam int SS = 2;
    localparam int CW = 8;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_SEQ  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_lock;
    logic          sw_rst_req;
    logic [ND-1:0] dom_rst_n;
    logic          ready;
    logic [1:0]    reset_cause;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reset_seq_gen #(
        .NUM_DOMAINS    (ND),
        .RESET_CYCLES   (RC),
        .STAGGER_CYCLES (SC),
        .SYNC_STAGES    (SS),
        .CTR_WIDTH      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .sw_rst_req  (sw_rst_req),
        .dom_rst_n   (dom_rst_n),
        .ready       (ready),
        .reset_cause (reset_cause)
    );

    // Reference model: mode plus the edge number at which holding began;
    // domain k is released once RC + k*SC edges have elapsed since then.
    int          edge_n = 0;
    int          m_mode = M_IDLE;
    int          m_start = 0;
    logic [1:0]  m_cause = 2'd0;
    logic [SS-1:0] m_rhist = '0;
    logic [SS-1:0] m_lhist = '0;

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode  <= M_IDLE;
            m_cause <= 2'd0;
            m_rhist <= '0;
            m_lhist <= '0;
            m_start <= 0;
        end else begin
            m_rhist <= {m_rhist[SS-2:0], 1'b1};
            m_lhist <= {m_lhist[SS-2:0], pll_lock};
            if (m_mode == M_IDLE) begin
                if (m_rhist[SS-1]) m_mode <= M_WAIT;
            end else if (m_mode == M_WAIT) begin
                if (m_lhist[SS-1]) begin
                    m_mode  <= M_SEQ;
                    m_start <= edge_n + 1;
                end
            end else begin
                if (!m_lhist[SS-1]) begin
                    m_mode  <= M_WAIT;
                    m_cause <= 2'd1;
                end else if (sw_rst_req) begin
                    m_mode  <= M_WAIT;
                    m_cause <= 2'd2;
                end
            end
        end
    end

    function automatic logic [ND-1:0] exp_dom();
        logic [ND-1:0] d;
        d = '0;
        for (int k = 0; k < ND; k++) begin
            if (m_mode == M_SEQ && (edge_n - m_start) >= RC + k * SC) d[k] = 1'b1;
        end
        return d;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_model();
        logic [ND-1:0] d;
        d = exp_dom();
        check("model_dom",   8'(dom_rst_n),   8'(d));
        check("model_ready", 8'(ready),       8'(&d));
        check("model_cause", 8'(reset_cause), 8'(m_cause));
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_model();
        end
    endtask

    // Absolute schedule: domain k released at edge first + k*SC.
    task automatic sched(input int e, input int first);
        logic [ND-1:0] d;
        d = '0;
        for (int k = 0; k < ND; k++) begin
            if (e >= first + k * SC) d[k] = 1'b1;
        end
        check("sched_dom",   8'(dom_rst_n), 8'(d));
        check("sched_ready", 8'(ready),     8'(&d));
    endtask

    initial begin
        rst_n      = 1'b1;
        pll_lock   = 1'b1;
        sw_rst_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("por_dom",   8'(dom_rst_n),   8'h00);
        check("por_ready", 8'(ready),       8'h00);
        check("por_cause", 8'(reset_cause), 8'h00);
        cyc(2);

        // Power-on with lock already high: releases at 9/12/15.
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            cyc(1);
            sched(e, 9);
        end
        check("po_cause", 8'(reset_cause), 8'h00);

        // Late lock: pll_lock rises just before edge 20.
        rst_n    = 1'b0;
        pll_lock = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            cyc(1);
            sched(e, 27);
            if (e == 19) pll_lock = 1'b1;
        end
        check("late_cause", 8'(reset_cause), 8'h00);

        // Software reset in RUN.
        sw_rst_req = 1'b1;
        cyc(1);
        sw_rst_req = 1'b0;
        check("sw_dom",   8'(dom_rst_n),   8'h00);
        check("sw_ready", 8'(ready),       8'h00);
        check("sw_cause", 8'(reset_cause), 8'h02);
        for (int e = 1; e <= 6; e++) begin
            cyc(1);
            sched(e, 6);
        end

        // Lock loss coinciding with sw_rst_req while in RELEASE.
        pll_lock = 1'b0;
        cyc(2);
        sw_rst_req = 1'b1;
        cyc(1);
        sw_rst_req = 1'b0;
        check("ll_dom",   8'(dom_rst_n),   8'h00);
        check("ll_cause", 8'(reset_cause), 8'h01);
        cyc(10);
        check("ll_hold_dom", 8'(dom_rst_n), 8'h00);
        pll_lock = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            cyc(1);
            sched(e, 8);
        end

        // Board reset mid-RELEASE, between edges.
        #2 rst_n = 1'b0;
        #1;
        check("async_dom",   8'(dom_rst_n),   8'h00);
        check("async_ready", 8'(ready),       8'h00);
        check("async_cause", 8'(reset_cause), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            cyc(1);
            sched(e, 9);
        end

        // sw_rst_req during WAIT_LOCK must be ignored.
        pll_lock = 1'b0;
        cyc(3);
        check("wl_cause0", 8'(reset_cause), 8'h01);
        cyc(2);
        sw_rst_req = 1'b1;
        cyc(1);
        sw_rst_req = 1'b0;
        check("wl_cause1", 8'(reset_cause), 8'h01);
        check("wl_dom",    8'(dom_rst_n),   8'h00);
        pll_lock = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            cyc(1);
            sched(e, 8);
        end
        check("wl_cause2", 8'(reset_cause), 8'h01);

        // Randomised phase checked against the model only.
        for (int i = 0; i < 800; i++) begin
            sw_rst_req = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 49) == 0) pll_lock = ~pll_lock;
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            cyc(1);
        end
        sw_rst_req = 1'b0;
        rst_n      = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
